// File: rtl/seq_alu_if.sv
// Handshake bundle for seq_alu: operand/op request channel and result channel.
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             err;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, zero, err
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, zero, err
    );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: handshaked RV32 ALU, base ops complete in one registered cycle.
// Define SEQ_ALU_MULDIV_EN to compile in the iterative RV32M multiply/divide path.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic     clk,
    input  logic     rst,
    seq_alu_if.slave bus
);
    // state | meaning
    // IDLE  | ready to accept an op
    // BUSY  | iterating multiply/divide, one step per cycle
    // DONE  | result presented, held until out_ready
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_SLT  = 5'b00101;
    localparam logic [4:0] OP_SLTU = 5'b00110;
    localparam logic [4:0] OP_SLL  = 5'b00111;
    localparam logic [4:0] OP_SRL  = 5'b01000;
    localparam logic [4:0] OP_SRA  = 5'b01001;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] base_res;
    logic             base_ok;

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.err       = err_q;

    always_comb begin
        base_res = '0;
        base_ok  = 1'b1;
        case (bus.op)
            OP_ADD:  base_res = bus.a + bus.b;
            OP_SUB:  base_res = bus.a - bus.b;
            OP_AND:  base_res = bus.a & bus.b;
            OP_OR:   base_res = bus.a | bus.b;
            OP_XOR:  base_res = bus.a ^ bus.b;
            OP_SLT:  base_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU: base_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            OP_SLL:  base_res = bus.a << bus.b[SHW-1:0];
            OP_SRL:  base_res = bus.a >> bus.b[SHW-1:0];
            OP_SRA:  base_res = $unsigned($signed(bus.a) >>> bus.b[SHW-1:0]);
            default: base_ok  = 1'b0;
        endcase
    end

`ifdef SEQ_ALU_MULDIV_EN
    localparam logic [4:0] OP_MULH   = 5'b10001;
    localparam logic [4:0] OP_MULHSU = 5'b10010;
    localparam logic [4:0] OP_DIV    = 5'b10100;
    localparam logic [4:0] OP_REM    = 5'b10110;
    // WIDTH is a power of two, so the start count is a single set bit
    localparam logic [SHW:0] CNT_INIT = {1'b1, {SHW{1'b0}}};
    localparam logic [SHW:0] CNT_ONE  = {{SHW{1'b0}}, 1'b1};

    logic [SHW:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic [2:0]         mop_q, mop_d;

    logic               is_m, sign_a, sign_b, spec_hit;
    logic [WIDTH-1:0]   mag_a, mag_b, spec_res;
    logic [WIDTH-1:0]   step_hi, step_lo, m_res;
    logic [WIDTH:0]     add_sum, rem_sh, rem_diff;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        is_m     = (bus.op[4:3] == 2'b10);
        sign_a   = bus.a[WIDTH-1] & ((bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
                                     (bus.op == OP_DIV)  || (bus.op == OP_REM));
        sign_b   = bus.b[WIDTH-1] & ((bus.op == OP_MULH) || (bus.op == OP_DIV) ||
                                     (bus.op == OP_REM));
        mag_a    = sign_a ? -bus.a : bus.a;
        mag_b    = sign_b ? -bus.b : bus.b;
        spec_hit = 1'b0;
        spec_res = '0;
        // divide by zero and signed overflow finish without iterating
        if (bus.op[4:2] == 3'b101) begin
            if (bus.b == '0) begin
                spec_hit = 1'b1;
                spec_res = bus.op[1] ? bus.a : '1;
            end else if (!bus.op[0] && (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.b == '1)) begin
                spec_hit = 1'b1;
                spec_res = bus.op[1] ? '0 : bus.a;
            end
        end
    end

    always_comb begin
        add_sum  = {1'b0, hi_q} + {1'b0, ({WIDTH{lo_q[0]}} & opnd_q)};
        rem_sh   = {hi_q, lo_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, opnd_q};
        if (mop_q[2]) begin
            step_hi = rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], ~rem_diff[WIDTH]};
        end else begin
            step_hi = add_sum[WIDTH:1];
            step_lo = {add_sum[0], lo_q[WIDTH-1:1]};
        end
        prod = {step_hi, step_lo};
        if (neg_q) begin
            prod = -prod;
        end
        if (mop_q[2]) begin
            if (mop_q[1]) begin
                m_res = rneg_q ? -step_hi : step_hi;
            end else begin
                m_res = neg_q ? -step_lo : step_lo;
            end
        end else begin
            m_res = (mop_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        err_d    = err_q;
`ifdef SEQ_ALU_MULDIV_EN
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        mop_d    = mop_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = DONE;
                    err_d   = 1'b0;
                    if (base_ok) begin
                        result_d = base_res;
                        zero_d   = (base_res == '0);
                    end
`ifdef SEQ_ALU_MULDIV_EN
                    else if (is_m && spec_hit) begin
                        result_d = spec_res;
                        zero_d   = (spec_res == '0);
                    end else if (is_m) begin
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                        hi_d    = '0;
                        lo_d    = bus.op[2] ? mag_a : mag_b;
                        opnd_d  = bus.op[2] ? mag_b : mag_a;
                        neg_d   = sign_a ^ sign_b;
                        rneg_d  = sign_a;
                        mop_d   = bus.op[2:0];
                    end
`endif
                    else begin
                        result_d = '0;
                        zero_d   = 1'b1;
                        err_d    = 1'b1;
                    end
                end
            end
`ifdef SEQ_ALU_MULDIV_EN
            BUSY: begin
                cnt_d = cnt_q - CNT_ONE;
                hi_d  = step_hi;
                lo_d  = step_lo;
                // last step writes the result directly so DONE follows WIDTH steps
                if (cnt_q == CNT_ONE) begin
                    state_d  = DONE;
                    result_d = m_res;
                    zero_d   = (m_res == '0);
                end
            end
`endif
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end

`ifdef SEQ_ALU_MULDIV_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            mop_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            opnd_q <= opnd_d;
            neg_q  <= neg_d;
            rneg_q <= rneg_d;
            mop_q  <= mop_d;
        end
    end
`endif
endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed vector table plus handshake/reset sequences.
// Expectations follow SEQ_ALU_MULDIV_EN the same way the design does.
module tb_seq_alu;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(W)) bus();
    seq_alu #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        logic [4:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_res;
        logic         exp_err;
        int           exp_lat;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] r, input logic e, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.exp_res = r; v.exp_err = e; v.exp_lat = lat;
        return v;
    endfunction

    // Called at posedge+1 while IDLE; leaves the bench at posedge+1 back in IDLE.
    task automatic run_vec(input vec_t v, input int idx);
        int   lat;
        logic rdy_low;
        check($sformatf("v%0d.ready_before", idx), W'(bus.in_ready), W'(1));
        bus.op = v.op; bus.a = v.a; bus.b = v.b;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a = $urandom; bus.b = $urandom; bus.op = 5'($urandom);
        lat = 1; rdy_low = 1'b1;
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready) rdy_low = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (bus.in_ready) rdy_low = 1'b0;
        check($sformatf("v%0d.latency", idx), W'(lat), W'(v.exp_lat));
        check($sformatf("v%0d.ready_low", idx), W'(rdy_low), W'(1));
        check($sformatf("v%0d.result", idx), bus.result, v.exp_res);
        check($sformatf("v%0d.zero", idx), W'(bus.zero), W'(v.exp_res == '0));
        check($sformatf("v%0d.err", idx), W'(bus.err), W'(v.exp_err));
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check($sformatf("v%0d.valid_after", idx), W'(bus.out_valid), W'(0));
        check($sformatf("v%0d.ready_after", idx), W'(bus.in_ready), W'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int           wcnt;
        logic         flag;
        logic [W-1:0] bp_res;
        logic         bp_err;

        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.op = '0; bus.a = '0; bus.b = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst.in_ready", W'(bus.in_ready), W'(1));
        check("rst.out_valid", W'(bus.out_valid), W'(0));
        check("rst.result", bus.result, '0);
        check("rst.zero", W'(bus.zero), W'(0));
        check("rst.err", W'(bus.err), W'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        vecs.push_back(mk(5'b00000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1));
        vecs.push_back(mk(5'b00001, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1));
        vecs.push_back(mk(5'b00010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1));
        vecs.push_back(mk(5'b00011, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1));
        vecs.push_back(mk(5'b00100, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1));
        vecs.push_back(mk(5'b00101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1));
        vecs.push_back(mk(5'b00101, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1));
        vecs.push_back(mk(5'b00110, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1));
        vecs.push_back(mk(5'b00110, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1));
        vecs.push_back(mk(5'b00111, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0, 1));
        vecs.push_back(mk(5'b00111, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 1));
        vecs.push_back(mk(5'b01000, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 1));
        vecs.push_back(mk(5'b01001, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 1));
        vecs.push_back(mk(5'b01001, 32'h7FFF_FFFF, 32'h0000_001F, 32'h0000_0000, 1'b0, 1));
        vecs.push_back(mk(5'b01100, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b1, 1));
        vecs.push_back(mk(5'b11111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1));
`ifdef SEQ_ALU_MULDIV_EN
        vecs.push_back(mk(5'b10001, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 1'b0, 33));
        vecs.push_back(mk(5'b10000, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, 1'b0, 33));
        vecs.push_back(mk(5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33));
        vecs.push_back(mk(5'b10010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 33));
        vecs.push_back(mk(5'b10100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, 33));
        vecs.push_back(mk(5'b10110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 33));
        vecs.push_back(mk(5'b10100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 33));
        vecs.push_back(mk(5'b10110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33));
        vecs.push_back(mk(5'b10101, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 1'b0, 33));
        vecs.push_back(mk(5'b10111, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 1'b0, 33));
        vecs.push_back(mk(5'b10101, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1));
        vecs.push_back(mk(5'b10111, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 1'b0, 1));
        vecs.push_back(mk(5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1));
        vecs.push_back(mk(5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1));
`else
        vecs.push_back(mk(5'b10000, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0000, 1'b1, 1));
        vecs.push_back(mk(5'b10100, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0000, 1'b1, 1));
        vecs.push_back(mk(5'b10111, 32'h0000_0007, 32'h0000_0000, 32'h0000_0000, 1'b1, 1));
`endif

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Backpressure: result must hold while out_ready is low; in_valid is ignored meanwhile.
`ifdef SEQ_ALU_MULDIV_EN
        bp_res = 32'hFFFF_FFFE; bp_err = 1'b0;
`else
        bp_res = 32'h0000_0000; bp_err = 1'b1;
`endif
        bus.op = 5'b10011; bus.a = 32'hFFFF_FFFF; bus.b = 32'hFFFF_FFFF;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wcnt = 0;
        while (!bus.out_valid && wcnt < 100) begin
            @(posedge clk); #1;
            wcnt++;
        end
        check("bp.valid_reached", W'(bus.out_valid), W'(1));
        bus.op = 5'b00000; bus.a = 32'h1; bus.b = 32'h1; bus.in_valid = 1'b1;
        flag = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (!bus.out_valid || bus.in_ready || bus.result !== bp_res) flag = 1'b0;
        end
        check("bp.held_stable", W'(flag), W'(1));
        check("bp.result", bus.result, bp_res);
        check("bp.err", W'(bus.err), W'(bp_err));
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("bp.valid_released", W'(bus.out_valid), W'(0));
        check("bp.ready_returns", W'(bus.in_ready), W'(1));

        // Reset five cycles into a DIVU: the op is dropped and never reported.
        bus.op = 5'b10101; bus.a = 32'd100; bus.b = 32'd7;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst.out_valid", W'(bus.out_valid), W'(0));
        check("mid_rst.in_ready", W'(bus.in_ready), W'(1));
        check("mid_rst.result", bus.result, '0);
        check("mid_rst.err", W'(bus.err), W'(0));
        flag = 1'b0;
        bus.out_ready = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid) flag = 1'b1;
        end
        bus.out_ready = 1'b0;
        check("mid_rst.no_stale", W'(flag), W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
